// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: segment sizing,
// configuration legality and the per-stage control payload.
package cla_pkg;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages, input int group);
        return (stages > 0) && (group > 0) && (width % stages == 0)
               && ((width / stages) % group == 0);
    endfunction

    // Control part of the stage payload; operand remainders and the accumulated
    // sum are width-dependent and sized per stage in the top level.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

endpackage

// File: rtl/cla_segment.sv
// Combinational carry-lookahead adder for one pipeline segment: lookahead inside
// each GROUP-bit group, ripple between groups.
module cla_segment #(
    parameter int SEG   = 32,
    parameter int GROUP = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic           g,
    output logic           p,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG-1:0] gb;
    logic [SEG-1:0] pb;
    logic [SEG:0]   c;
    logic           gg;
    logic           pp;

    assign gb = a & b;
    assign pb = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        gg   = 1'b0;
        pp   = 1'b1;
        g    = 1'b0;
        p    = 1'b1;
        for (int i = 0; i < SEG; i++) begin
            g = gb[i] | (pb[i] & g);
            p = p & pb[i];
        end
        // Every carry in a group is formed from that group's carry-in, not the previous bit.
        for (int grp = 0; grp < SEG / GROUP; grp++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = 0; j < GROUP; j++) begin
                gg = gb[grp*GROUP + j] | (pb[grp*GROUP + j] & gg);
                pp = pp & pb[grp*GROUP + j];
                c[grp*GROUP + j + 1] = gg | (pp & c[grp*GROUP]);
            end
        end
    end

    assign sum   = pb ^ c[SEG-1:0];
    assign cout  = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one segment resolves per stage, carry registered
// between stages, valid/ready on both sides with a single global stall.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES, GROUP)) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must split into STAGES segments of whole GROUPs");
    end

    logic              advance;
    logic [STAGES-1:0] unused_seg;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int W_IN = WIDTH - k * SEG;
        localparam int REM  = W_IN - SEG;
        localparam int ACC  = (k + 1) * SEG;

        logic [W_IN-1:0] a_in;
        logic [W_IN-1:0] b_in;
        logic            c_in;
        logic            v_in;
        logic [SEG-1:0]  seg_sum;
        logic            seg_g;
        logic            seg_p;
        logic            seg_cout;
        logic            seg_cmsb;
        logic [ACC-1:0]  acc_next;
        stage_ctrl_t     ctrl_q;
        logic [ACC-1:0]  acc_q;

        if (k == 0) begin : g_first
            assign a_in     = a;
            assign b_in     = sub ? ~b : b;
            assign c_in     = sub | cin;
            assign v_in     = in_valid;
            assign acc_next = seg_sum;
        end else begin : g_next
            assign a_in     = g_stage[k-1].g_rem.a_q;
            assign b_in     = g_stage[k-1].g_rem.b_q;
            assign c_in     = g_stage[k-1].ctrl_q.carry;
            assign v_in     = g_stage[k-1].ctrl_q.valid;
            assign acc_next = {seg_sum, g_stage[k-1].acc_q};
        end

        cla_segment #(.SEG(SEG), .GROUP(GROUP)) u_seg (
            .a     (a_in[SEG-1:0]),
            .b     (b_in[SEG-1:0]),
            .cin   (c_in),
            .g     (seg_g),
            .p     (seg_p),
            .sum   (seg_sum),
            .cout  (seg_cout),
            .c_msb (seg_cmsb)
        );

        // Segment g/p would feed a cross-segment lookahead; here carries are registered instead.
        assign unused_seg[k] = seg_g ^ seg_p ^ seg_cmsb;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ctrl_q <= '0;
                acc_q  <= '0;
            end else if (advance) begin
                ctrl_q <= '{valid: v_in, carry: seg_cout};
                acc_q  <= acc_next;
            end
        end

        if (k < STAGES - 1) begin : g_rem
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[W_IN-1:SEG];
                    b_q <= b_in[W_IN-1:SEG];
                end
            end
        end else begin : g_last
            logic ovf_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= seg_cmsb ^ seg_cout;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].ctrl_q.valid;
    assign cout      = g_stage[STAGES-1].ctrl_q.carry;
    assign sum       = g_stage[STAGES-1].acc_q;
    assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for the pipelined CLA adder: default 64/2/4 instance plus a
// 32/4/4 instance streamed against a bench-side arithmetic model.
module tb_pipelined_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst_n1, in_valid1, in_ready1, cin1, sub1, out_valid1, out_ready1, cout1, ovf1;
    logic [63:0] a1, b1, sum1;

    logic        rst_n2, in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
    logic [31:0] a2, b2, sum2;

    pipelined_cla_adder #(.WIDTH(64), .STAGES(2), .GROUP(4)) dut1 (
        .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    pipelined_cla_adder #(.WIDTH(32), .STAGES(4), .GROUP(4)) dut2 (
        .clk(clk), .rst_n(rst_n2), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .overflow(ovf2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; out_ready1 must be 1.
    task automatic beat1(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                         input logic tcin, input logic tsub,
                         input logic [63:0] esum, input logic ecout, input logic eovf);
        a1 = ta; b1 = tb; cin1 = tcin; sub1 = tsub; in_valid1 = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready1, 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(negedge clk);
        check({tag, "_early_valid"}, out_valid1, 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, out_valid1, 1);
        check({tag, "_sum"}, sum1, esum);
        check({tag, "_cout"}, cout1, ecout);
        check({tag, "_ovf"}, ovf1, eovf);
        @(posedge clk); #1;
    endtask

    logic [63:0] exp5 [4] = '{64'd2, 64'd4, 64'd6, 64'd8};
    logic [33:0] model_q [$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, nout, last_cyc, seen;
        logic take;
        logic [31:0] be;
        logic [32:0] r;
        logic        movf;
        logic [33:0] expv;

        rst_n1 = 0; in_valid1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; out_ready1 = 0;
        rst_n2 = 0; in_valid2 = 0; a2 = 0; b2 = 0; cin2 = 0; sub2 = 0; out_ready2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid1, 0);
        check("rst_sum", sum1, 0);
        check("rst_cout", cout1, 0);
        check("rst_ovf", ovf1, 0);
        @(posedge clk); #1;
        rst_n1 = 1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", in_ready1, 1);
        @(posedge clk); #1;
        out_ready1 = 1;

        beat1("t1_add", 64'h3011, 64'h0200_0000_0000_2050, 0, 0, 64'h0200_0000_0000_5061, 0, 0);
        beat1("t2_carry32", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0, 64'h0, 1, 0);
        beat1("t3_sub_neg", 64'd5, 64'd7, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
        beat1("t3_sub_pos", 64'd7, 64'd5, 0, 1, 64'd2, 1, 0);
        beat1("t3_sub_cin_ign", 64'd7, 64'd5, 1, 1, 64'd2, 1, 0);
        beat1("t4_pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'h8000_0000_0000_0000, 0, 1);
        beat1("t4_sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1);
        beat1("t4_wrap", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 64'h0, 1, 1);

        // Back-to-back beats with a 3-cycle downstream stall after the first result.
        idx = 0; nout = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid1  = (idx < 4);
            a1         = 64'(idx + 1);
            b1         = 64'(idx + 1);
            cin1       = 0;
            sub1       = 0;
            out_ready1 = !(cyc >= 2 && cyc <= 4);
            @(negedge clk);
            if (cyc >= 2 && cyc <= 4) begin
                check("t5_stall_in_ready", in_ready1, 0);
                check("t5_stall_valid", out_valid1, 1);
                check("t5_stall_sum", sum1, 64'd2);
            end
            if (out_valid1 && out_ready1) begin
                check("t5_no_extra", (nout < 4), 1);
                if (nout < 4) check("t5_order", sum1, exp5[nout]);
                nout++;
                last_cyc = cyc;
            end
            take = in_valid1 && in_ready1;
            @(posedge clk); #1;
            if (take) idx++;
        end
        check("t5_count", nout, 4);
        check("t5_last_cycle", last_cyc, 8);
        out_ready1 = 1;

        // Reset while two beats are in flight.
        a1 = 64'd10; b1 = 64'd20; in_valid1 = 1;
        @(posedge clk); #1;
        a1 = 64'd30; b1 = 64'd40;
        @(posedge clk); #1;
        in_valid1 = 0; rst_n1 = 0;
        @(negedge clk);
        check("t6_first_beat", sum1, 64'd30);
        @(posedge clk); #1;
        rst_n1 = 1;
        @(negedge clk);
        check("t6_rst_valid", out_valid1, 0);
        check("t6_rst_in_ready", in_ready1, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid1) seen++;
        end
        check("t6_no_stale", seen, 0);

        // 32-bit, 4-stage instance.
        @(negedge clk);
        check("d2_rst_valid", out_valid2, 0);
        @(posedge clk); #1;
        rst_n2 = 1; out_ready2 = 1;
        @(posedge clk); #1;
        a2 = 32'hFFFF_FFFF; b2 = 0; cin2 = 1; sub2 = 0; in_valid2 = 1;
        @(posedge clk); #1;
        in_valid2 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("d2_latency_early", out_valid2, 0);
            @(posedge clk);
        end
        @(negedge clk);
        check("d2_latency_valid", out_valid2, 1);
        check("d2_carry_chain", {ovf2, cout2, sum2}, {1'b0, 1'b1, 32'h0});
        @(posedge clk); #1;

        a2 = 32'd10; b2 = 32'd20; cin2 = 0; in_valid2 = 1;
        @(posedge clk); #1;
        a2 = 32'd30; b2 = 32'd40;
        @(posedge clk); #1;
        in_valid2 = 0; rst_n2 = 0;
        @(posedge clk); #1;
        rst_n2 = 1;
        @(negedge clk);
        check("d2_rst_valid_mid", out_valid2, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid2) seen++;
        end
        check("d2_no_stale", seen, 0);
        @(posedge clk); #1;

        // Random stream with random backpressure against the arithmetic model.
        for (int cyc = 0; cyc < 320; cyc++) begin
            in_valid2  = (cyc < 260) ? ($urandom_range(0, 3) != 0) : 1'b0;
            a2         = $urandom;
            b2         = $urandom;
            cin2       = 1'($urandom_range(0, 1));
            sub2       = 1'($urandom_range(0, 1));
            out_ready2 = (cyc >= 280) ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid2 && out_ready2) begin
                check("rnd_expected_beat", (model_q.size() != 0), 1);
                if (model_q.size() != 0) begin
                    expv = model_q.pop_front();
                    check("rnd_result", {ovf2, cout2, sum2}, expv);
                end
            end
            if (in_valid2 && in_ready2) begin
                be   = sub2 ? ~b2 : b2;
                r    = {1'b0, a2} + {1'b0, be} + 33'(sub2 ? 1'b1 : cin2);
                movf = (a2[31] == be[31]) && (r[31] != a2[31]);
                model_q.push_back({movf, r[32], r[31:0]});
            end
            @(posedge clk); #1;
        end
        check("rnd_drained", model_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
